// File: rtl/obi_mem_responder.sv
// OBI-style subordinate memory with an in-order response FIFO.
// The environment throttles grant and response timing through the stall inputs.
module obi_mem_responder #(
    parameter int ADDR_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        gnt_stall_i,
    input  logic        rvalid_stall_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [2:0]  outstanding_o
);

    localparam int          DEPTH   = 2 ** ADDR_WIDTH;
    localparam int          PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]  MAX_CNT = 3'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [31:0]           r_mem  [DEPTH];
    logic [31:0]           r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      r_wptr;
    logic [2:0]            r_count;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_push_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused;

    // Upper address bits alias onto the memory; the byte offset is ignored.
    assign w_idx       = addr_i[ADDR_WIDTH+1:2];
    assign w_unused    = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
    assign w_rd_word   = r_mem[w_idx];
    assign w_push_data = we_i ? 32'h0 : w_rd_word;

    // Full check uses the registered count, so a same-cycle pop never frees a slot.
    assign gnt_o    = rst_ni & req_i & ~gnt_stall_i & (r_count < MAX_CNT);
    assign rvalid_o = rst_ni & (r_count != 3'd0) & ~rvalid_stall_i;
    assign rdata_o  = rvalid_o ? r_fifo[r_rptr] : 32'h0;
    assign outstanding_o = r_count;

    assign w_push = gnt_o;
    assign w_pop  = rvalid_o;

    always_ff @(posedge clk_i) begin
        if (w_push && we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder with default parameters (8-bit word index, 2 outstanding).
module tb_obi_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_stall_i;
    logic        rvalid_stall_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [2:0]  outstanding_o;

    int checks = 0;
    int errors = 0;

    obi_mem_responder #(.ADDR_WIDTH(8), .MAX_OUTSTANDING(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .wdata_i        (wdata_i),
        .gnt_stall_i    (gnt_stall_i),
        .rvalid_stall_i (rvalid_stall_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic req, input logic [31:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wd);
        req_i   = req;
        addr_i  = addr;
        we_i    = we;
        be_i    = be;
        wdata_i = wd;
        #1;
    endtask

    task automatic idle();
        set_req(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    // Full-word write followed by one cycle to drain its response.
    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        set_req(1'b1, addr, 1'b1, 4'hF, data);
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        set_req(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt_o); end
        next_cycle();
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt2 got %b want 0", gnt_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outst got %0d want 0", outstanding_o); end
        rst_ni = 1'b1;
        idle();
        next_cycle();
    endtask

    task automatic test_single_read();
        preload(32'h10, 32'hDEADBEEF);
        set_req(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b want 1", gnt_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_no_zero_latency got %b want 0", rvalid_o); end
        next_cycle();
        idle();
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", rdata_o); end
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL rd_outst1 got %0d want 1", outstanding_o); end
        next_cycle();
        checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL rd_outst0 got %0d want 0", outstanding_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_end got %b want 0", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rd_rdata_idle got %h want 0", rdata_o); end
    endtask

    task automatic test_byte_enable();
        preload(32'h20, 32'hAABBCCDD);
        set_req(1'b1, 32'h20, 1'b1, 4'b0101, 32'h11223344);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL be_wr_gnt got %b want 1", gnt_o); end
        next_cycle();
        set_req(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL be_wr_rvalid got %b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL be_wr_rdata got %h want 0", rdata_o); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL be_rd_gnt got %b want 1", gnt_o); end
        next_cycle();
        idle();
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL be_rd_rvalid got %b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'hAA22CC44) begin errors++; $display("FAIL be_rd_rdata got %h want aa22cc44", rdata_o); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        preload(32'h4, 32'h0000_0101);
        preload(32'h8, 32'h0000_0202);
        preload(32'hC, 32'h0000_0303);
        rvalid_stall_i = 1'b1;
        set_req(1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL bp_gnt0 got %b want 1", gnt_o); end
        next_cycle();
        set_req(1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL bp_gnt1 got %b want 1", gnt_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL bp_stalled_rvalid got %b want 0", rvalid_o); end
        next_cycle();
        set_req(1'b1, 32'hC, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL bp_full_gnt[%0d] got %b want 0", i, gnt_o); end
            checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL bp_full_outst[%0d] got %0d want 2", i, outstanding_o); end
            next_cycle();
        end
        rvalid_stall_i = 1'b0;
        #1;
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL bp_resp0_rvalid got %b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'h101) begin errors++; $display("FAIL bp_resp0_rdata got %h want 101", rdata_o); end
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL bp_pop_no_gnt got %b want 0", gnt_o); end
        next_cycle();
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL bp_third_gnt got %b want 1", gnt_o); end
        checks++; if (rdata_o !== 32'h202) begin errors++; $display("FAIL bp_resp1_rdata got %h want 202", rdata_o); end
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL bp_outst1 got %0d want 1", outstanding_o); end
        next_cycle();
        idle();
        checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL bp_pushpop_outst got %0d want 1", outstanding_o); end
        checks++; if (rdata_o !== 32'h303) begin errors++; $display("FAIL bp_resp2_rdata got %h want 303", rdata_o); end
        next_cycle();
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL bp_empty_rvalid got %b want 0", rvalid_o); end
        rvalid_stall_i = 1'b1;
        #1;
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL bp_empty_stall_rvalid got %b want 0", rvalid_o); end
        rvalid_stall_i = 1'b0;
    endtask

    task automatic test_gnt_stall();
        gnt_stall_i = 1'b1;
        set_req(1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL gs_gnt[%0d] got %b want 0", i, gnt_o); end
            checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL gs_outst[%0d] got %0d want 0", i, outstanding_o); end
            next_cycle();
        end
        gnt_stall_i = 1'b0;
        #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL gs_release_gnt got %b want 1", gnt_o); end
        next_cycle();
        idle();
        checks++; if (rdata_o !== 32'h202) begin errors++; $display("FAIL gs_rdata got %h want 202", rdata_o); end
        next_cycle();
    endtask

    task automatic test_alias();
        preload(32'h0000_0400, 32'h5);
        set_req(1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0);
        next_cycle();
        idle();
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL alias_rvalid got %b want 1", rvalid_o); end
        checks++; if (rdata_o !== 32'h5) begin errors++; $display("FAIL alias_rdata got %h want 5", rdata_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        rvalid_stall_i = 1'b1;
        set_req(1'b1, 32'h4, 1'b0, 4'h0, 32'h0);
        next_cycle();
        set_req(1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
        next_cycle();
        idle();
        checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL rm_pre_outst got %0d want 2", outstanding_o); end
        rst_ni = 1'b0;
        rvalid_stall_i = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rm_rvalid[%0d] got %b want 0", i, rvalid_o); end
            checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL rm_outst[%0d] got %0d want 0", i, outstanding_o); end
            next_cycle();
        end
        set_req(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        next_cycle();
        idle();
        checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rm_mem_kept got %h want deadbeef", rdata_o); end
        next_cycle();
    endtask

    initial begin
        rst_ni         = 1'b0;
        req_i          = 1'b0;
        addr_i         = 32'h0;
        we_i           = 1'b0;
        be_i           = 4'h0;
        wdata_i        = 32'h0;
        gnt_stall_i    = 1'b0;
        rvalid_stall_i = 1'b0;
        #2;
        test_reset();
        test_single_read();
        test_byte_enable();
        test_back_to_back();
        test_gnt_stall();
        test_alias();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
